// File: rtl/cache_types_pkg.sv
// Shared types for the cache controller: FSM state encoding and datapath mux selects.
package cache_types_pkg;

    typedef enum logic [1:0] {
        Idle      = 2'd0,
        Writeback = 2'd1,
        Fetch     = 2'd2
    } state_e;

    // data_sel: source of data written into the data array
    localparam logic DataSelCpu  = 1'b0;
    localparam logic DataSelPmem = 1'b1;

    // addr_sel: source of the tag presented to physical memory
    localparam logic AddrSelCpu    = 1'b0;
    localparam logic AddrSelVictim = 1'b1;

endpackage

// File: rtl/cache_control.sv
// Two-way set-associative cache control FSM (IDLE / WRITEBACK / FETCH).
// Hits respond in the same cycle; misses write back a dirty LRU victim, fetch the line
// and return to IDLE, where the held request is retried and hits.
// Optional hit/miss performance counters are built when CACHE_CTRL_PERF_EN is defined;
// otherwise hit_count and miss_count are tied to zero.
module cache_control
    import cache_types_pkg::*;
#(
    parameter int unsigned s_index = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic        mem_resp,
    input  logic [1:0]  hit,
    input  logic [1:0]  valid,
    input  logic [1:0]  dirty,
    input  logic        lru,
    output logic [1:0]  load_tag,
    output logic [1:0]  load_valid,
    output logic [1:0]  load_dirty,
    output logic        dirty_in,
    output logic [1:0]  load_data,
    output logic        data_sel,
    output logic        load_lru,
    output logic        lru_in,
    output logic        way_sel,
    output logic        addr_sel,
    output logic        pmem_read,
    output logic        pmem_write,
    input  logic        pmem_resp,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    if (s_index < 1) begin : g_bad_s_index
        $error("cache_control: s_index must be at least 1");
    end

    state_e state_q, state_d;
    logic   victim_q, victim_d;
    logic   hit_way;

    // Both ways matching is illegal; resolve it to way 0.
    assign hit_way = hit[0] ? 1'b0 : 1'b1;

    // Next-state and Mealy outputs; everything is held at zero while rst is high.
    always_comb begin
        state_d    = state_q;
        victim_d   = victim_q;
        mem_resp   = 1'b0;
        load_tag   = 2'b00;
        load_valid = 2'b00;
        load_dirty = 2'b00;
        dirty_in   = 1'b0;
        load_data  = 2'b00;
        data_sel   = DataSelCpu;
        load_lru   = 1'b0;
        lru_in     = 1'b0;
        way_sel    = 1'b0;
        addr_sel   = AddrSelCpu;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        if (!rst) begin
            unique case (state_q)
                Idle: begin
                    if (mem_read || mem_write) begin
                        if (|hit) begin
                            mem_resp = 1'b1;
                            way_sel  = hit_way;
                            load_lru = 1'b1;
                            lru_in   = ~hit_way;
                            if (mem_write) begin
                                load_data[hit_way]  = 1'b1;
                                data_sel            = DataSelCpu;
                                load_dirty[hit_way] = 1'b1;
                                dirty_in            = 1'b1;
                            end
                        end else begin
                            victim_d = lru;
                            state_d  = (valid[lru] && dirty[lru]) ? Writeback : Fetch;
                        end
                    end
                end
                Writeback: begin
                    pmem_write = 1'b1;
                    addr_sel   = AddrSelVictim;
                    way_sel    = victim_q;
                    if (pmem_resp) state_d = Fetch;
                end
                Fetch: begin
                    pmem_read = 1'b1;
                    addr_sel  = AddrSelCpu;
                    if (pmem_resp) begin
                        load_data[victim_q]  = 1'b1;
                        load_tag[victim_q]   = 1'b1;
                        load_valid[victim_q] = 1'b1;
                        load_dirty[victim_q] = 1'b1;
                        data_sel             = DataSelPmem;
                        dirty_in             = 1'b0;
                        state_d              = Idle;
                    end
                end
                default: state_d = Idle;
            endcase
        end
    end

    // State and victim-way registers; victim is captured only when leaving IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= Idle;
            victim_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
        end
    end

`ifdef CACHE_CTRL_PERF_EN
    logic [31:0] hit_count_q, miss_count_q;
    logic        miss_event;

    assign miss_event = !rst && (state_q == Idle) && (state_d != Idle);

    // Free-running wrap-around hit/miss counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            if (mem_resp)   hit_count_q  <= hit_count_q + 32'd1;
            if (miss_event) miss_count_q <= miss_count_q + 32'd1;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_control.sv
// Self-checking bench for cache_control: per-cycle expected outputs are queued as
// stimulus is applied and compared by a negedge monitor; counters checked inline.
module tb_cache_control;

    typedef struct packed {
        logic       mem_resp;
        logic [1:0] load_tag;
        logic [1:0] load_valid;
        logic [1:0] load_dirty;
        logic       dirty_in;
        logic [1:0] load_data;
        logic       data_sel;
        logic       load_lru;
        logic       lru_in;
        logic       way_sel;
        logic       addr_sel;
        logic       pmem_read;
        logic       pmem_write;
    } out_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write, mem_resp;
    logic [1:0]  hit, valid, dirty;
    logic        lru;
    logic [1:0]  load_tag, load_valid, load_dirty, load_data;
    logic        dirty_in, data_sel, load_lru, lru_in, way_sel, addr_sel;
    logic        pmem_read, pmem_write, pmem_resp;
    logic [31:0] hit_count, miss_count;

    int   vectors = 0;
    int   fails   = 0;
    out_t exp_q[$];
    string cur_name = "none";
    out_t obs;

    cache_control #(.s_index(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_resp   (mem_resp),
        .hit        (hit),
        .valid      (valid),
        .dirty      (dirty),
        .lru        (lru),
        .load_tag   (load_tag),
        .load_valid (load_valid),
        .load_dirty (load_dirty),
        .dirty_in   (dirty_in),
        .load_data  (load_data),
        .data_sel   (data_sel),
        .load_lru   (load_lru),
        .lru_in     (lru_in),
        .way_sel    (way_sel),
        .addr_sel   (addr_sel),
        .pmem_read  (pmem_read),
        .pmem_write (pmem_write),
        .pmem_resp  (pmem_resp),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    assign obs = '{mem_resp, load_tag, load_valid, load_dirty, dirty_in, load_data, data_sel,
                   load_lru, lru_in, way_sel, addr_sel, pmem_read, pmem_write};

    // Scoreboard: pop one expectation per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            out_t e;
            e = exp_q.pop_front();
            vectors++;
            if (obs !== e) begin
                fails++;
                $display("FAIL %s @%0t: outputs got %b want %b (resp,tag,valid,dirty,din,data,dsel,llru,lruin,way,asel,prd,pwr)",
                         cur_name, $time, obs, e);
            end
        end
    end

    function automatic out_t zero_exp();
        out_t e;
        e = '0;
        return e;
    endfunction

    function automatic out_t hit_exp(input logic wr, input logic way);
        out_t e;
        e = '0;
        e.mem_resp = 1'b1;
        e.way_sel  = way;
        e.load_lru = 1'b1;
        e.lru_in   = ~way;
        if (wr) begin
            e.load_data[way]  = 1'b1;
            e.load_dirty[way] = 1'b1;
            e.dirty_in        = 1'b1;
        end
        return e;
    endfunction

    function automatic out_t wb_exp(input logic way);
        out_t e;
        e = '0;
        e.pmem_write = 1'b1;
        e.addr_sel   = 1'b1;
        e.way_sel    = way;
        return e;
    endfunction

    function automatic out_t fetch_exp(input logic done, input logic way);
        out_t e;
        e = '0;
        e.pmem_read = 1'b1;
        if (done) begin
            e.load_data[way]  = 1'b1;
            e.load_tag[way]   = 1'b1;
            e.load_valid[way] = 1'b1;
            e.load_dirty[way] = 1'b1;
            e.data_sel        = 1'b1;
        end
        return e;
    endfunction

    // Apply current inputs for one cycle with the given expected outputs.
    task automatic step(input out_t e);
        exp_q.push_back(e);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_read = 0; mem_write = 0; hit = 2'b00; valid = 2'b00; dirty = 2'b00;
        lru = 0; pmem_resp = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        step(zero_exp());
        rst = 0;
    endtask

    // Read or write miss with a fixed number of wait cycles per pmem phase, then retry hit.
    task automatic do_miss(input logic wr, input logic vic, input logic [1:0] v,
                           input logic [1:0] d, input int wb_cycles, input int fe_cycles);
        mem_read = ~wr; mem_write = wr; hit = 2'b00; valid = v; dirty = d; lru = vic;
        step(zero_exp());
        lru = ~vic;  // datapath LRU changing must not move the registered victim
        if (v[vic] && d[vic]) begin
            for (int i = 1; i <= wb_cycles; i++) begin
                pmem_resp = (i == wb_cycles);
                step(wb_exp(vic));
            end
        end
        for (int i = 1; i <= fe_cycles; i++) begin
            pmem_resp = (i == fe_cycles);
            step(fetch_exp(i == fe_cycles, vic));
        end
        pmem_resp = 0;
        hit = vic ? 2'b10 : 2'b01;
        step(hit_exp(wr, vic));
        idle_inputs();
    endtask

    task automatic test_reset();
        cur_name = "reset";
        idle_inputs();
        mem_read = 1; hit = 2'b01; pmem_resp = 1;
        rst = 1;
        step(zero_exp());
        step(zero_exp());
        vectors++;
        if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
            fails++;
            $display("FAIL reset_counters: got %0d/%0d want 0/0", hit_count, miss_count);
        end
        rst = 0;
        idle_inputs();
        step(zero_exp());
    endtask

    task automatic test_read_hit();
        cur_name = "read_hit";
        mem_read = 1; hit = 2'b01; lru = 0;
        step(hit_exp(1'b0, 1'b0));
        hit = 2'b10; lru = 1;
        step(hit_exp(1'b0, 1'b1));
        idle_inputs();
        step(zero_exp());
    endtask

    task automatic test_write_hit();
        cur_name = "write_hit";
        mem_write = 1; hit = 2'b10; valid = 2'b11;
        step(hit_exp(1'b1, 1'b1));
        hit = 2'b01;
        step(hit_exp(1'b1, 1'b0));
        idle_inputs();
        step(zero_exp());
    endtask

    task automatic test_illegal_hit();
        cur_name = "illegal_hit";
        mem_read = 1; hit = 2'b11; lru = 1;
        step(hit_exp(1'b0, 1'b0));
        mem_read = 0; mem_write = 1;
        step(hit_exp(1'b1, 1'b0));
        idle_inputs();
    endtask

    task automatic test_writeback_miss();
        cur_name = "writeback_miss";
        do_miss(1'b0, 1'b1, 2'b11, 2'b10, 5, 3);
        cur_name = "idle_pmem_resp";
        pmem_resp = 1;
        step(zero_exp());
        pmem_resp = 0;
    endtask

    task automatic test_clean_miss();
        cur_name = "clean_miss";
        do_miss(1'b0, 1'b0, 2'b11, 2'b00, 0, 2);
        cur_name = "invalid_dirty_miss";
        do_miss(1'b1, 1'b1, 2'b01, 2'b10, 0, 1);
    endtask

    task automatic test_reset_fetch();
        cur_name = "reset_fetch";
        mem_read = 1; hit = 2'b00; valid = 2'b11; dirty = 2'b00; lru = 0;
        step(zero_exp());
        step(fetch_exp(1'b0, 1'b0));
        step(fetch_exp(1'b0, 1'b0));
        rst = 1; pmem_resp = 1;
        step(zero_exp());
        rst = 0; mem_read = 0;
        step(zero_exp());
        pmem_resp = 0; mem_read = 1; hit = 2'b01;
        step(hit_exp(1'b0, 1'b0));
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        cur_name = "back_to_back";
        mem_read = 1; hit = 2'b10;
        step(hit_exp(1'b0, 1'b1));
        mem_read = 0; mem_write = 1; hit = 2'b01;
        step(hit_exp(1'b1, 1'b0));
        do_miss(1'b1, 1'b0, 2'b11, 2'b01, 2, 2);
    endtask

    task automatic test_perf();
        logic [31:0] want_hits, want_miss;
        cur_name = "perf";
        idle_inputs();
        do_reset();
        mem_read = 1; hit = 2'b01;
        step(hit_exp(1'b0, 1'b0));
        mem_read = 0; mem_write = 1; hit = 2'b10;
        step(hit_exp(1'b1, 1'b1));
        mem_write = 0; mem_read = 1; hit = 2'b01;
        step(hit_exp(1'b0, 1'b0));
        idle_inputs();
        do_miss(1'b0, 1'b0, 2'b01, 2'b00, 0, 1);
        do_miss(1'b1, 1'b1, 2'b11, 2'b10, 1, 1);
`ifdef CACHE_CTRL_PERF_EN
        want_hits = 32'd5;
        want_miss = 32'd2;
`else
        want_hits = 32'd0;
        want_miss = 32'd0;
`endif
        vectors++;
        if (hit_count !== want_hits) begin
            fails++;
            $display("FAIL hit_count: got %0d want %0d", hit_count, want_hits);
        end
        vectors++;
        if (miss_count !== want_miss) begin
            fails++;
            $display("FAIL miss_count: got %0d want %0d", miss_count, want_miss);
        end
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        #1;
        test_reset();
        test_read_hit();
        test_write_hit();
        test_illegal_hit();
        test_writeback_miss();
        test_clean_miss();
        test_reset_fetch();
        test_back_to_back();
        test_perf();
        @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/cache_control.md
CACHE_CONTROL -- requirements
Module: cache_control

Interface
REQ-001 Parameter s_index, default 3: set index width; consistent with the tag/valid/dirty/LRU/data arrays it sequences.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 mem_read  input  1  CPU read request, held until mem_resp.
REQ-005 mem_write  input  1  CPU write request, held until mem_resp; never asserted together with mem_read.
REQ-006 mem_resp  output  1  one-cycle completion pulse to CPU.
REQ-007 hit  input  2  per-way tag match AND valid, from datapath.
REQ-008 valid  input  2  per-way valid bit of indexed set.
REQ-009 dirty  input  2  per-way dirty bit of indexed set.
REQ-010 lru  input  1  indexed set LRU bit; value = least-recently-used way.
REQ-011 load_tag  output  2  per-way tag array write enable.
REQ-012 load_valid  output  2  per-way valid array write enable; written value is always 1.
REQ-013 load_dirty  output  2  per-way dirty array write enable.
REQ-014 dirty_in  output  1  value written to dirty array.
REQ-015 load_data  output  2  per-way data array write enable.
REQ-016 data_sel  output  1  0 = data from CPU write path, 1 = data from pmem line.
REQ-017 load_lru, lru_in  output  1 each  LRU array write enable / value.
REQ-018 way_sel  output  1  way driving read data / writeback line.
REQ-019 addr_sel  output  1  pmem address source: 0 = CPU tag, 1 = victim tag (writeback).
REQ-020 pmem_read, pmem_write  output  1 each  physical memory requests, held until pmem_resp.
REQ-021 pmem_resp  input  1  physical memory completion pulse.
REQ-022 hit_count, miss_count  output  32 each  performance counters (see Configuration).

Function
REQ-023 States: IDLE, WRITEBACK, FETCH; all outputs default 0 unless stated.
REQ-024 IDLE, request with |hit: mem_resp=1 same cycle; way_sel=hit way; load_lru=1, lru_in=other way; stay IDLE.
REQ-025 Write hit additionally: load_data[hit way]=1, data_sel=0, load_dirty[hit way]=1, dirty_in=1.
REQ-026 IDLE, request with hit==0: victim=lru; valid[victim]&dirty[victim] -> WRITEBACK, else -> FETCH; mem_resp=0.
REQ-027 WRITEBACK: pmem_write=1, addr_sel=1, way_sel=victim until pmem_resp; on pmem_resp -> FETCH.
REQ-028 FETCH: pmem_read=1, addr_sel=0 until pmem_resp; on pmem_resp: load_data/load_tag/load_valid/load_dirty[victim]=1, data_sel=1, dirty_in=0, -> IDLE.
REQ-029 Victim way is registered on leaving IDLE and held through WRITEBACK/FETCH.
REQ-030 After FETCH the retried request hits in IDLE; total miss latency = pmem latencies + 2 cycles.
REQ-031 pmem_read and pmem_write never both asserted; pmem_resp outside WRITEBACK/FETCH ignored.
REQ-032 hit==2'b11 (illegal) resolves to way 0.

Reset
REQ-033 rst in any state -> IDLE next edge; all outputs 0 that cycle, including mid-WRITEBACK/FETCH (transaction abandoned).
REQ-034 rst clears hit_count and miss_count to 0 and victim register to 0.

Configuration
REQ-035 Macro CACHE_CTRL_PERF_EN defined: hit_count increments on each IDLE hit response, miss_count on each IDLE->WRITEBACK/FETCH transition; both wrap at 2^32.
REQ-036 Macro undefined: counter registers not built; hit_count, miss_count tied to 0.

Structure
REQ-037 Package cache_types_pkg holds state enum (IDLE, WRITEBACK, FETCH) and data_sel/addr_sel mux encodings.
REQ-038 No sub-modules; optional counters internal to cache_control.

Verification
REQ-039 Read, hit=2'b01, lru=0 -> mem_resp same cycle, way_sel=0, load_lru=1, lru_in=1.
REQ-040 Write, hit=2'b10 -> load_data=2'b10, load_dirty=2'b10, dirty_in=1, mem_resp=1.
REQ-041 Read miss, lru=1, valid=2'b11, dirty=2'b10 -> WRITEBACK, pmem_write until pmem_resp after 5 cycles, then FETCH, fill way 1, dirty_in=0.
REQ-042 Read miss, lru=0, dirty=2'b00 -> FETCH directly, no pmem_write, mem_resp one cycle after fill.
REQ-043 rst asserted third cycle of FETCH -> next cycle IDLE, pmem_read=0, no array loads.
REQ-044 CACHE_CTRL_PERF_EN: 3 hits + 2 misses -> hit_count=5 (retries hit), miss_count=2; undefined -> both 0.
